// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one UART transmitter between N_CH
//   byte-stream requesters. Bytes are accepted over per-channel valid/ready
//   and handed to the transmitter through its drl/load/din handshake. A
//   multi-byte packet (up to and including the byte flagged req_last) locks
//   the arbiter onto its channel so packets are never interleaved.
//
// Ports:
//   clk        in   system clock, rising edge
//   res        in   synchronous active-high reset (shared with the transmitter)
//   req_valid  in   [N_CH]    per-channel byte available
//   req_data   in   [8*N_CH]  per-channel byte, channel i at [8*i+7:8*i]
//   req_last   in   [N_CH]    per-channel end-of-packet flag
//   req_ready  out  [N_CH]    one-hot accept strobe (IDLE only)
//   tx_drl     out            data-ready-to-load request to the transmitter
//   tx_load    in             transmitter load pulse
//   tx_din     out  [8]       byte presented to the transmitter
//   gnt_ch     out  [CH_BITS] channel that last won the transmitter
//   busy       out            not IDLE, or a packet lock is held
//   byte_cnt   out  [CNT_W]   bytes handed to the transmitter (wrapping)
// -----------------------------------------------------------------------------
module tx_arbiter #(
  parameter  int CH_BITS = 2,
  parameter  int CNT_W   = 16,
  localparam int N_CH    = 2 ** CH_BITS
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [8*N_CH-1:0]    req_data,
  input  logic [N_CH-1:0]      req_last,
  output logic [N_CH-1:0]      req_ready,
  output logic                 tx_drl,
  input  logic                 tx_load,
  output logic [7:0]           tx_din,
  output logic [CH_BITS-1:0]   gnt_ch,
  output logic                 busy,
  output logic [CNT_W-1:0]     byte_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CH_BITS-1:0] ptr_q, ptr_d;
  logic               lock_q, lock_d;
  logic [CH_BITS-1:0] lock_ch_q, lock_ch_d;
  logic               last_q, last_d;
  logic [7:0]         din_q, din_d;
  logic [CH_BITS-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CH_BITS-1:0] win;
  logic               win_vld;
  logic               accept;

  // Round-robin search starting at ptr. The loop runs from the farthest
  // offset down to offset 0 so the closest eligible channel is assigned last
  // and therefore wins. While locked only lock_ch is eligible.
  always_comb begin
    logic [CH_BITS-1:0] idx;
    win     = ptr_q;
    win_vld = 1'b0;
    idx     = ptr_q;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = ptr_q + CH_BITS'(i);
      if (req_valid[idx] && (!lock_q || idx == lock_ch_q)) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign accept = (state_q == IDLE) && win_vld;

  // State register. Every register, including the packet lock, is cleared so
  // a reset mid-packet leaves nothing behind.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      last_q    <= 1'b0;
      din_q     <= 8'h00;
      gnt_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      last_q    <= last_d;
      din_q     <= din_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and datapath update.
  // NOTE: every signal gets a hold-value default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    last_d    = last_q;
    din_d     = din_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          din_d   = req_data[8*win +: 8];
          gnt_d   = win;
          last_d  = req_last[win];
          if (!req_last[win]) begin
            lock_d    = 1'b1;
            lock_ch_d = win;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        if (tx_load) state_d = HOLD;
      end
      HOLD: begin
        // din_q is untouched here: the transmitter samples it this cycle.
        cnt_d = cnt_q + 1'b1;
        if (last_q) begin
          lock_d = 1'b0;
          ptr_d  = gnt_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready is combinational from req_valid.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
    tx_drl = (state_q == REQ);
    busy   = (state_q != IDLE) || lock_q;
  end

  assign tx_din   = din_q;
  assign gnt_ch   = gnt_q;
  assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_arbiter
//
// Self-checking bench for tx_arbiter. Per-channel source queues feed the
// requesters, a simple transmitter model answers tx_drl with tx_load after a
// programmable delay, and a scoreboard of expected {channel, byte} entries is
// compared against tx_din/gnt_ch in every HOLD cycle. Built with CNT_W=4 so
// the byte counter wrap is reachable quickly.
// -----------------------------------------------------------------------------
module tb_tx_arbiter;

  localparam int CH_BITS = 2;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 4;

  logic                clk = 1'b0;
  logic                res;
  logic [N_CH-1:0]     req_valid;
  logic [8*N_CH-1:0]   req_data;
  logic [N_CH-1:0]     req_last;
  logic [N_CH-1:0]     req_ready;
  logic                tx_drl;
  logic                tx_load;
  logic [7:0]          tx_din;
  logic [CH_BITS-1:0]  gnt_ch;
  logic                busy;
  logic [CNT_W-1:0]    byte_cnt;

  tx_arbiter #(.CH_BITS(CH_BITS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .res       (res),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_drl    (tx_drl),
    .tx_load   (tx_load),
    .tx_din    (tx_din),
    .gnt_ch    (gnt_ch),
    .busy      (busy),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_BITS-1:0] ch;
    logic [7:0]         data;
  } exp_t;

  exp_t            exp_q[$];
  logic [8:0]      src_q[N_CH][$];   // {last, data}

  int              n_checks = 0;
  int              n_fail   = 0;
  int              tx_delay = 1;
  int              tx_wait  = 0;
  logic            hold_next = 1'b0;
  logic            load_next;
  logic [N_CH-1:0] pop_mask = '0;
  logic [CNT_W-1:0] model_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit any_src();
    for (int i = 0; i < N_CH; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N_CH; i++) begin
      if (src_q[i].size() != 0) begin
        req_valid[i]        = 1'b1;
        req_last[i]         = src_q[i][0][8];
        req_data[8*i +: 8]  = src_q[i][0][7:0];
      end else begin
        req_valid[i]        = 1'b0;
        req_last[i]         = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic push_src(input int ch, input logic last, input logic [7:0] data);
    src_q[ch].push_back({last, data});
  endtask

  task automatic expect_byte(input int ch, input logic [7:0] data);
    exp_t e;
    e.ch   = CH_BITS'(ch);
    e.data = data;
    exp_q.push_back(e);
  endtask

  // One clock: sample at the falling edge, then update inputs 1 time unit
  // after the rising edge.
  task automatic step();
    @(negedge clk);
    if (hold_next) begin
      if (exp_q.size() == 0) begin
        check("unexpected_hold", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hold_din", tx_din, e.data);
        check("hold_gnt", gnt_ch, e.ch);
      end
      check("hold_drl", tx_drl, 1'b0);
      check("hold_cnt", byte_cnt, model_cnt);
      model_cnt++;
    end
    hold_next = tx_drl && tx_load;
    if (tx_drl) begin
      check("req_no_ready", req_ready, '0);
      if (exp_q.size() != 0) check("req_din_stable", tx_din, exp_q[0].data);
    end
    if (req_ready != '0) check("ready_onehot", $countones(req_ready), 1);
    pop_mask = req_valid & req_ready;
    load_next = 1'b0;
    if (tx_drl && !tx_load) begin
      if (tx_wait >= tx_delay) begin
        load_next = 1'b1;
        tx_wait   = 0;
      end else begin
        tx_wait++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_CH; i++) if (pop_mask[i]) void'(src_q[i].pop_front());
    tx_load = load_next;
    drive_inputs();
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || any_src()) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("timeout", 32'd1, 32'd0);
    step();
    step();
    check("idle_busy", busy, 1'b0);
  endtask

  task automatic do_reset();
    res = 1'b1;
    for (int i = 0; i < N_CH; i++) src_q[i].delete();
    exp_q.delete();
    tx_load   = 1'b0;
    tx_wait   = 0;
    hold_next = 1'b0;
    pop_mask  = '0;
    model_cnt = '0;
    drive_inputs();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_drl",   tx_drl,    1'b0);
    check("rst_din",   tx_din,    8'h00);
    check("rst_gnt",   gnt_ch,    '0);
    check("rst_cnt",   byte_cnt,  '0);
    check("rst_busy",  busy,      1'b0);
    check("rst_ready", req_ready, '0);
    @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res       = 1'b1;
    tx_load   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;

    // Single byte on ch1 with a 2-cycle transmitter delay.
    do_reset();
    tx_delay = 2;
    push_src(1, 1'b1, 8'hA5);
    expect_byte(1, 8'hA5);
    drive_inputs();
    #2;
    check("single_ready", req_ready, 4'b0010);
    step();
    #2;
    check("single_drl", tx_drl, 1'b1);
    run_until_done(50);
    check("single_cnt", byte_cnt, 1);

    // Packet lock: ptr is now 2. ch2 stalls mid-packet while ch0/ch1 wait.
    tx_delay = 1;
    push_src(2, 1'b0, 8'h01);
    push_src(0, 1'b1, 8'h50);
    push_src(1, 1'b1, 8'h51);
    expect_byte(2, 8'h01);
    expect_byte(2, 8'h02);
    expect_byte(2, 8'h03);
    expect_byte(0, 8'h50);   // ptr = 3 after the packet: 3,0,1 -> ch0 first
    expect_byte(1, 8'h51);
    drive_inputs();
    run_cycles(20);
    #2;
    check("lock_busy",  busy,      1'b1);
    check("lock_ready", req_ready, '0);
    push_src(2, 1'b0, 8'h02);
    push_src(2, 1'b1, 8'h03);
    drive_inputs();
    run_until_done(200);

    // Backpressure: 500 cycles in REQ with another channel waiting.
    tx_delay = 500;
    push_src(0, 1'b1, 8'h77);
    push_src(1, 1'b1, 8'h78);
    expect_byte(0, 8'h77);   // ptr = 2 after ch1: 2,3,0 -> ch0
    expect_byte(1, 8'h78);
    drive_inputs();
    run_until_done(2000);
    tx_delay = 1;

    // Round-robin from reset with all channels valid.
    do_reset();
    push_src(0, 1'b1, 8'h10);
    push_src(0, 1'b1, 8'h14);
    push_src(1, 1'b1, 8'h11);
    push_src(2, 1'b1, 8'h12);
    push_src(3, 1'b1, 8'h13);
    expect_byte(0, 8'h10);
    expect_byte(1, 8'h11);
    expect_byte(2, 8'h12);
    expect_byte(3, 8'h13);
    expect_byte(0, 8'h14);
    drive_inputs();
    run_until_done(200);

    // Counter wrap: 16 bytes on a 4-bit counter.
    do_reset();
    tx_delay = 0;
    for (int k = 0; k < 16; k++) begin
      push_src(k % N_CH, 1'b1, 8'h80 + 8'(k));
      expect_byte(k % N_CH, 8'h80 + 8'(k));
    end
    drive_inputs();
    run_until_done(400);
    check("wrap_cnt", byte_cnt, '0);
    tx_delay = 1;

    // Reset while in REQ during a locked ch1 packet.
    do_reset();
    tx_delay = 1000;
    push_src(1, 1'b0, 8'hAA);
    push_src(1, 1'b1, 8'hBB);
    expect_byte(1, 8'hAA);
    drive_inputs();
    for (int n = 0; n < 20 && !tx_drl; n++) step();
    check("mid_in_req", tx_drl, 1'b1);
    step();
    step();
    check("mid_locked", busy, 1'b1);
    res = 1'b1;
    src_q[1].delete();
    exp_q.delete();
    tx_load   = 1'b0;
    tx_wait   = 0;
    hold_next = 1'b0;
    pop_mask  = '0;
    model_cnt = '0;
    drive_inputs();
    @(posedge clk);
    #1;
    res = 1'b0;
    #2;
    check("mid_drl",  tx_drl,   1'b0);
    check("mid_busy", busy,     1'b0);
    check("mid_cnt",  byte_cnt, '0);
    tx_delay = 1;
    push_src(3, 1'b1, 8'hC3);
    expect_byte(3, 8'hC3);
    drive_inputs();
    run_until_done(100);
    check("mid_after_cnt", byte_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter between N_CH byte-stream requesters.
- Accepts bytes over per-channel valid/ready and presents them to the transmitter's drl/load/din handshake.
- A multi-byte packet (bytes up to and including one flagged req_last) is never interleaved with other channels.
- Sits between protocol/message sources and the serial transmitter; same clock domain and same reset as the transmitter.

Parameters:
- CH_BITS, 2, width of the channel index. N_CH = 2**CH_BITS requesters.
- CNT_W, 16, width of the sent-byte counter.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- res  input  1  reset. Synchronous, active-high; also drives the transmitter's res.
- req_valid  input  N_CH  per-channel byte available.
- req_data  input  8*N_CH  per-channel byte; channel i occupies bits [8*i+7:8*i].
- req_last  input  N_CH  per-channel end-of-packet flag, qualified by req_valid.
- req_ready  output  N_CH  one-hot accept strobe. A byte transfers when req_valid[i] and req_ready[i] are both high.
- tx_drl  output  1  data-ready-to-load request to the transmitter.
- tx_load  input  1  transmitter load pulse. Asserted one cycle after the transmitter idles with drl high.
- tx_din  output  8  byte presented to the transmitter.
- gnt_ch  output  CH_BITS  channel currently owning the transmitter (last granted).
- busy  output  1  high when not in IDLE or when a packet lock is held.
- byte_cnt  output  CNT_W  total bytes handed to the transmitter.

Behaviour:
- Reset values (res sampled high on an edge):
  - state=IDLE; ptr=0; lock=0; lock_ch=0.
  - tx_drl=0; tx_din=8'h00; gnt_ch=0; byte_cnt=0; req_ready=0.
  - Reset mid-operation abandons any pending byte and any packet lock. No partial state survives.
- FSM has three states: IDLE, REQ, HOLD.
- IDLE:
  - Candidate set = lock ? {lock_ch} : all channels.
  - Winner = first channel with req_valid=1 searching ptr, ptr+1, ... wrapping modulo N_CH.
  - req_ready[winner] = 1 combinationally in the same cycle; all other bits are 0. req_ready is 0 outside IDLE.
  - On a transfer:
    - tx_din <= req_data[winner]; gnt_ch <= winner.
    - Capture last_flag <= req_last[winner].
    - If the byte is not last: lock <= 1, lock_ch <= winner.
    - Next state REQ.
  - If no candidate is valid, stay in IDLE. While locked, other channels' valid bytes are ignored, even indefinitely.
- REQ:
  - tx_drl = 1, decoded from state, so it rises the cycle after acceptance.
  - Stay until tx_load=1. The transmitter may be mid-frame; waiting is unbounded.
  - On tx_load=1: next state HOLD.
- HOLD:
  - tx_drl = 0. tx_din is held stable, because the transmitter samples din in this cycle.
  - byte_cnt <= byte_cnt+1, wrapping to 0 at all-ones.
  - If last_flag: lock <= 0 and ptr <= gnt_ch+1 (mod N_CH).
  - Next state IDLE.
- Timing rules:
  - Minimum spacing between accepts is 3 cycles.
  - tx_din changes only on an IDLE transfer. It is never modified between acceptance and the end of HOLD.
- Fairness:
  - ptr advances only when a packet completes, so each channel gets at most one packet per round.
  - A single-byte packet (req_last=1) never sets lock.
- Simultaneous events:
  - Several valid requests: the round-robin winner from ptr is taken; the others keep valid and wait.
  - tx_load in any state other than REQ is ignored.
  - A valid request arriving in the same cycle HOLD completes waits for the next IDLE cycle.
- gnt_ch holds its value until the next acceptance.

Test Plan:
- Single byte: res pulse, then ch1 valid with data=8'hA5, last=1.
  - Expect req_ready[1] in that cycle; tx_drl high the next cycle.
  - Drive tx_load after 2 cycles: tx_din=8'hA5 during HOLD; byte_cnt=1; ptr=2; tx_drl drops.
- Round-robin: ch0..ch3 all valid with single-byte packets 8'h10..8'h13, transmitter modelled as a real Transmitter instance.
  - Expect service order 0,1,2,3, then 0 again. Serial tx stream decodes 10,11,12,13.
- Packet lock: ch2 sends 8'h01(last=0), 8'h02(last=0), 8'h03(last=1) while ch0 stays valid.
  - Expect ch2 bytes back-to-back before any ch0 accept; afterwards ptr=3 and ch0 is served next.
- Backpressure: hold tx_load low for 500 cycles in REQ.
  - Expect tx_drl stays 1, tx_din stable, no req_ready; resumes on the tx_load pulse.
- Reset mid-packet: assert res in REQ during a locked ch1 packet.
  - Next cycle expect tx_drl=0, busy=0, byte_cnt=0, lock cleared; ch3 valid is then accepted.
- Counter wrap: preload via 2**CNT_W accepts (or a CNT_W=4 build, 16 bytes).
  - Expect byte_cnt returns to 0.
